top_alu_seq: RTL and testbench
==============================

Name: top_alu_seq

Overview:
Parametrised successor to the board-level ALU top.
- Conditions NB_BUT push-buttons: synchroniser, optional debounce, rising-edge pulse.
- Runs an ordered load sequence: operand A, operand B, opcode. Computes the result internally and registers it with status flags and a valid bit for the LEDs.
- Sits between board switches/buttons and LEDs. Replaces the free-order latch-on-level scheme.

Parameters:
NB_DATA, 8, operand/result width (signed, two's complement)
NB_OP, 6, opcode width
NB_BUT, 3, button count (btn0=A, btn1=B, btn2=OP; extra buttons ignored)
DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a level (macro on only)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_sw  in  NB_DATA  switch value; opcode taken from i_sw[NB_OP-1:0]
i_btn  in  NB_BUT  raw asynchronous buttons
o_led  out  NB_DATA  registered result
o_valid  out  1  result corresponds to current A/B/op
o_zero  out  1  registered result == 0
o_overflow  out  1  signed overflow of last ADD/SUB, else 0
o_state  out  2  FSM state for debug LEDs

Behaviour:
- Reset (asynchronous, immediate, any state): state=WAIT_A; A, B, op = 0; o_led=0; o_valid=0; o_zero=0; o_overflow=0; sync/debounce/edge registers=0.
- A button held through reset release yields exactly one pulse after release.
- Per button: 2-FF synchroniser.
  - Accepted level follows the synchronised level (macro off) or the debounced level (macro on).
  - Registered pulse = accepted & ~accepted_d, one cycle wide.
- Pulse priority in the same cycle: btn0 > btn1 > btn2. Losing pulses are dropped, not queued.
- FSM, o_state encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, SHOW=3; EXEC is an internal substate reported as 2.
  - WAIT_A: btn0 pulse -> A<=i_sw, go WAIT_B. Other pulses ignored.
  - WAIT_B: btn1 pulse -> B<=i_sw, go WAIT_OP. btn0 pulse -> reload A, stay.
  - WAIT_OP: btn2 pulse -> op<=i_sw[NB_OP-1:0], go EXEC. btn0 -> reload A, go WAIT_B.
  - EXEC: one cycle. o_led/o_zero/o_overflow <= ALU(A,B,op); o_valid<=1; go SHOW. Pulses arriving in EXEC are dropped.
  - SHOW: outputs held.
    - btn0 pulse -> A<=i_sw, o_valid<=0, go WAIT_B.
    - btn2 pulse -> op<=i_sw, o_valid<=0, go EXEC (re-run with the same A/B).
    - btn1 ignored.
- Latency:
  - Pulse in cycle n -> register loaded at edge n.
  - Opcode pulse at n -> o_valid=1 after edge n+1.
  - Raw button high at edge k -> pulse at edge k+2, macro off.
- Operations (package codes):
  - ADD 100000, SUB 100010: wrap modulo 2^NB_DATA; o_overflow = signed overflow.
  - AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRL 000010, SRA 000011: A shifted by unsigned B. If B >= NB_DATA, SRL gives 0 and SRA gives all sign bits.
  - Undefined opcode: result 0, o_zero=1, o_overflow=0.
- i_sw changes outside a load pulse have no effect.

Optional Feature:
TOP_ALU_DEBOUNCE_EN
- Defined: per-button counter.
  - Increments while the synchronised level differs from the accepted level; cleared on agreement.
  - At DEBOUNCE_CYCLES the accepted level flips and the counter clears.
  - Pulse delay becomes k+2+DEBOUNCE_CYCLES.
- Undefined: no counter; accepted = synchronised level. DEBOUNCE_CYCLES is unused.

Decomposition:
- Package top_alu_pkg: opcode localparams, FSM state encoding, NB_STATE=2.
- Sub-module btn_conditioner (sync, optional debounce, edge pulse), one instance per button via generate.
- ALU datapath and FSM stay in top_alu_seq.

Test Plan:
- Reset; A=8'h05 (btn0), B=8'h03 (btn1), op=6'b100000 (btn2) -> o_led=8'h08, o_valid=1, o_zero=0, o_overflow=0, o_state=3.
- A=8'h7F, B=8'h01, ADD -> o_led=8'h80, o_overflow=1. Then btn2 with op=6'b100010 and A=B=8'h7F reload -> o_led=0, o_zero=1.
- In WAIT_A, pulse btn1 and btn2 -> state stays 0, B and op unchanged. In SHOW, btn0+btn2 in the same cycle -> A loaded, state=1, o_valid=0.
- A=8'h80, B=8'd9, SRA -> 8'hFF; SRL -> 8'h00. Opcode 6'b111111 -> o_led=0, o_zero=1.
- Macro on, DEBOUNCE_CYCLES=16:
  - btn0 toggling every 3 cycles for 60 cycles -> no load.
  - btn0 held 20 cycles -> exactly one A load.
- i_rst_n low during EXEC -> o_led, o_valid, flags = 0 immediately (before next edge); o_state=0; btn0 held through release -> one load.

Source files
------------

// File: rtl/top_alu_pkg.sv
// -----------------------------------------------------------------------------
// top_alu_pkg
// Shared definitions for the sequenced board ALU: opcode values, the internal
// FSM state type and the mapping of those states onto the 2-bit debug code.
// -----------------------------------------------------------------------------
package top_alu_pkg;

    localparam int NB_STATE = 2;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_EXEC,
        ST_SHOW
    } state_t;

    // EXEC lasts a single cycle and is shown on the LEDs as WAIT_OP.
    function automatic logic [NB_STATE-1:0] state_code(input state_t s);
        case (s)
            ST_WAIT_A:           return 2'd0;
            ST_WAIT_B:           return 2'd1;
            ST_WAIT_OP, ST_EXEC: return 2'd2;
            ST_SHOW:             return 2'd3;
            default:             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/top_alu_seq_btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw asynchronous push-button into a single-cycle registered pulse
// on each accepted rising level: 2-FF synchroniser, optional debounce, edge.
// Macro TOP_ALU_DEBOUNCE_EN: when defined, a level is accepted only after
// DEBOUNCE_CYCLES consecutive samples that disagree with the current one.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   btn_i   raw button input
//   pulse_o one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic acc;
    logic acc_prev_q;
    logic pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef TOP_ALU_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_q;
    logic             acc_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        cnt_d = '0;
        acc_d = acc_q;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = ~acc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`else
    // Threshold only matters when debouncing is compiled in.
    localparam int unused_deb_cycles = DEBOUNCE_CYCLES;

    assign acc = sync2_q;
`endif

    // Previous level starts at 0, so a button held through reset release
    // still produces one pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_prev_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            acc_prev_q <= acc;
            pulse_q    <= acc & ~acc_prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/top_alu_seq.sv
// -----------------------------------------------------------------------------
// top_alu_seq
// Board ALU with an ordered load sequence: btn0 loads A, btn1 loads B, btn2
// loads the opcode and triggers a one-cycle execute; the result, flags and a
// valid bit are then held for the LEDs.
// Macro TOP_ALU_DEBOUNCE_EN enables per-button debouncing.
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_sw        switch value (opcode from i_sw[NB_OP-1:0])
//   i_btn       raw buttons (btn0=A, btn1=B, btn2=OP, others ignored)
//   o_led       registered result
//   o_valid     result matches the current A/B/op
//   o_zero      registered result is zero
//   o_overflow  signed overflow of the last ADD/SUB
//   o_state     debug state code
// -----------------------------------------------------------------------------
module top_alu_seq
    import top_alu_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int NB_BUT          = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NB_DATA-1:0]  i_sw,
    input  logic [NB_BUT-1:0]   i_btn,
    output logic [NB_DATA-1:0]  o_led,
    output logic                o_valid,
    output logic                o_zero,
    output logic                o_overflow,
    output logic [NB_STATE-1:0] o_state
);

    localparam int MSB = NB_DATA - 1;
    localparam logic [NB_DATA-1:0] SHIFT_LIM = NB_DATA'(NB_DATA);

    logic [NB_BUT-1:0] btn_pulse;

    for (genvar gi = 0; gi < NB_BUT; gi++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk_i  (i_clk),
            .rst_ni (i_rst_n),
            .btn_i  (i_btn[gi]),
            .pulse_o(btn_pulse[gi])
        );
    end

    // Only the highest-priority pulse of a cycle survives.
    logic take_a, take_b, take_op;
    assign take_a  = btn_pulse[0];
    assign take_b  = btn_pulse[1] & ~btn_pulse[0];
    assign take_op = btn_pulse[2] & ~btn_pulse[1] & ~btn_pulse[0];

    // Returns {overflow, result}.
    function automatic logic [NB_DATA:0] alu_calc(
        input logic signed [NB_DATA-1:0] a,
        input logic signed [NB_DATA-1:0] b,
        input logic        [NB_OP-1:0]   op
    );
        logic signed [NB_DATA-1:0] r;
        logic                      ov;
        logic        [NB_DATA-1:0] sh;
        r  = '0;
        ov = 1'b0;
        sh = $unsigned(b);
        case (op)
            NB_OP'(OP_ADD): begin
                r  = a + b;
                ov = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
            end
            NB_OP'(OP_SUB): begin
                r  = a - b;
                ov = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
            end
            NB_OP'(OP_AND): r = a & b;
            NB_OP'(OP_OR):  r = a | b;
            NB_OP'(OP_XOR): r = a ^ b;
            NB_OP'(OP_NOR): r = ~(a | b);
            NB_OP'(OP_SRL): begin
                if (sh >= SHIFT_LIM) r = '0;
                else                 r = a >> sh;
            end
            NB_OP'(OP_SRA): begin
                // Kept as if/else so the arithmetic shift stays signed.
                if (sh >= SHIFT_LIM) r = {NB_DATA{a[MSB]}};
                else                 r = a >>> sh;
            end
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    state_t                     state_q, state_d;
    logic signed [NB_DATA-1:0]  a_q, a_d;
    logic signed [NB_DATA-1:0]  b_q, b_d;
    logic        [NB_OP-1:0]    op_q, op_d;
    logic        [NB_DATA-1:0]  led_q, led_d;
    logic                       valid_q, valid_d;
    logic                       zero_q, zero_d;
    logic                       ovf_q, ovf_d;
    logic        [NB_DATA:0]    alu_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_WAIT_A;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_A:  if (take_a) state_d = ST_WAIT_B;
            ST_WAIT_B:  if (take_b) state_d = ST_WAIT_OP;
            ST_WAIT_OP: if (take_a) state_d = ST_WAIT_B;
                        else if (take_op) state_d = ST_EXEC;
            ST_EXEC:    state_d = ST_SHOW;
            ST_SHOW:    if (take_a) state_d = ST_WAIT_B;
                        else if (take_op) state_d = ST_EXEC;
            default:    state_d = ST_WAIT_A;
        endcase
    end

    always_comb begin
        o_state = state_code(state_q);
    end

    // Register loads; EXEC drops all pulses and only captures the ALU output.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        led_d   = led_q;
        valid_d = valid_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        alu_out = alu_calc(a_q, b_q, op_q);
        case (state_q)
            ST_WAIT_A: if (take_a) a_d = i_sw;
            ST_WAIT_B: begin
                if (take_a)      a_d = i_sw;
                else if (take_b) b_d = i_sw;
            end
            ST_WAIT_OP: begin
                if (take_a)       a_d  = i_sw;
                else if (take_op) op_d = i_sw[NB_OP-1:0];
            end
            ST_EXEC: begin
                led_d   = alu_out[NB_DATA-1:0];
                ovf_d   = alu_out[NB_DATA];
                zero_d  = (alu_out[NB_DATA-1:0] == '0);
                valid_d = 1'b1;
            end
            ST_SHOW: begin
                if (take_a) begin
                    a_d     = i_sw;
                    valid_d = 1'b0;
                end else if (take_op) begin
                    op_d    = i_sw[NB_OP-1:0];
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            led_q   <= led_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_led      = led_q;
    assign o_valid    = valid_q;
    assign o_zero     = zero_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_top_alu_seq.sv
module tb_top_alu_seq;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int NB_BUT  = 3;
    localparam int DEB     = 16;
`ifdef TOP_ALU_DEBOUNCE_EN
    localparam int D = 2 + DEB;   // raw edge to pulse, in clock edges
`else
    localparam int D = 2;
`endif
    localparam int HOLD   = D + 2;
    localparam int SETTLE = D + 3;

    localparam logic [5:0] C_ADD = 6'b100000, C_SUB = 6'b100010, C_AND = 6'b100100,
                           C_OR  = 6'b100101, C_XOR = 6'b100110, C_NOR = 6'b100111,
                           C_SRL = 6'b000010, C_SRA = 6'b000011;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NB_DATA-1:0] sw = '0;
    logic [NB_BUT-1:0]  btn = '0;
    logic [NB_DATA-1:0] led;
    logic               valid, zero, ovf;
    logic [1:0]         st;

    top_alu_seq #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_BUT(NB_BUT), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_btn(btn),
        .o_led(led), .o_valid(valid), .o_zero(zero), .o_overflow(ovf), .o_state(st)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [12:0] obs;
    logic [12:0] exp_v;
    assign obs = {led, valid, zero, ovf, st};

    function automatic logic [12:0] ev(input logic [7:0] l, input logic v, input logic z,
                                       input logic o, input logic [1:0] s);
        return {l, v, z, o, s};
    endfunction

    // Reference ALU from the operation table, using plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        int sa, sb, s;
        logic [7:0] r;
        logic ov;
        sa = $signed(a);
        sb = $signed(b);
        r  = 8'h00;
        ov = 1'b0;
        s  = 0;
        case (op)
            C_ADD: begin s = sa + sb; r = s[7:0]; ov = (s > 127) || (s < -128); end
            C_SUB: begin s = sa - sb; r = s[7:0]; ov = (s > 127) || (s < -128); end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_XOR: r = a ^ b;
            C_NOR: r = ~(a | b);
            C_SRL: r = (b >= 8) ? 8'h00 : (a >> b);
            C_SRA: begin
                if (b >= 8) r = a[7] ? 8'hFF : 8'h00;
                else begin s = sa >>> b; r = s[7:0]; end
            end
            default: r = 8'h00;
        endcase
        return {ov, r};
    endfunction

    task automatic press(input logic [2:0] mask, input logic [7:0] v);
        @(posedge clk); #1;
        sw  = v;
        btn = mask;
        repeat (HOLD) @(posedge clk);
        #1 btn = '0;
        repeat (SETTLE) @(posedge clk);
        #1 sw = 8'($urandom);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        btn = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        exp_v = ev(8'h00, 0, 0, 0, 2'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_state: got=%h want=%h", obs, exp_v); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        press(3'b001, 8'h05);
        exp_v = ev(8'h00, 0, 0, 0, 2'd1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL basic_load_a: got=%h want=%h", obs, exp_v); end
        press(3'b010, 8'h03);
        exp_v = ev(8'h00, 0, 0, 0, 2'd2);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL basic_load_b: got=%h want=%h", obs, exp_v); end
        press(3'b100, {2'b00, C_ADD});
        exp_v = ev(8'h08, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL basic_add: got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_overflow();
        press(3'b001, 8'h7F);
        press(3'b010, 8'h01);
        press(3'b100, {2'b00, C_ADD});
        exp_v = ev(8'h80, 1, 0, 1, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ovf_add: got=%h want=%h", obs, exp_v); end
        press(3'b001, 8'h7F);
        exp_v = ev(8'h80, 0, 0, 1, 2'd1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ovf_reload_a: got=%h want=%h", obs, exp_v); end
        press(3'b010, 8'h7F);
        press(3'b100, {2'b00, C_SUB});
        exp_v = ev(8'h00, 1, 1, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL ovf_sub_zero: got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_ignored();
        do_reset();
        press(3'b010, 8'hAA);
        press(3'b100, 8'hAA);
        exp_v = ev(8'h00, 0, 0, 0, 2'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL wait_a_ignore: got=%h want=%h", obs, exp_v); end
        press(3'b001, 8'h21);
        press(3'b010, 8'h02);
        press(3'b100, {2'b00, C_ADD});
        press(3'b010, 8'h55);
        exp_v = ev(8'h23, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL show_ignore_b: got=%h want=%h", obs, exp_v); end
        press(3'b100, {2'b00, C_ADD});
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL show_rerun: got=%h want=%h", obs, exp_v); end
        press(3'b101, 8'h11);
        exp_v = ev(8'h23, 0, 0, 0, 2'd1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL show_prio_a: got=%h want=%h", obs, exp_v); end
        press(3'b010, 8'h02);
        press(3'b100, {2'b00, C_ADD});
        exp_v = ev(8'h13, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL show_prio_result: got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_shift();
        press(3'b001, 8'h80);
        press(3'b010, 8'd9);
        press(3'b100, {2'b00, C_SRA});
        exp_v = ev(8'hFF, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL sra_big: got=%h want=%h", obs, exp_v); end
        press(3'b100, 8'h3F);
        exp_v = ev(8'h00, 1, 1, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL undef_op: got=%h want=%h", obs, exp_v); end
        press(3'b100, {2'b00, C_SRA});
        press(3'b100, {2'b00, C_SRL});
        exp_v = ev(8'h00, 1, 1, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL srl_big: got=%h want=%h", obs, exp_v); end
    endtask

    task automatic test_random();
        logic [5:0] ops [14];
        logic [7:0] a, b;
        logic [5:0] op;
        logic [8:0] r;
        ops = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SRL, C_SRA,
                C_ADD, C_SUB, C_SRA, 6'h00, 6'h3F, 6'h21};
        for (int i = 0; i < 30; i++) begin
            a  = 8'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            op = ops[$urandom_range(0, 13)];
            press(3'b001, a);
            press(3'b010, b);
            press(3'b100, {2'b00, op});
            r = ref_alu(a, b, op);
            exp_v = ev(r[7:0], 1, r[7:0] == 8'h00, r[8], 2'd3);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rand_op a=%h b=%h op=%b: got=%h want=%h", a, b, op, obs, exp_v);
            end
            op = ops[$urandom_range(0, 13)];
            press(3'b100, {2'b00, op});
            r = ref_alu(a, b, op);
            exp_v = ev(r[7:0], 1, r[7:0] == 8'h00, r[8], 2'd3);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL rand_rerun a=%h b=%h op=%b: got=%h want=%h", a, b, op, obs, exp_v);
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        @(posedge clk); #1;
        sw  = 8'h40;
        btn = 3'b001;
        repeat (D + 1) @(posedge clk);
        #1;
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL lat_early_load: got=%0d want=0", st); end
        @(posedge clk); #1;
        total++;
        if (st !== 2'd1) begin bad++; $display("FAIL lat_load_edge: got=%0d want=1", st); end
        btn = '0;
        repeat (SETTLE) @(posedge clk);
        #1;
        press(3'b010, 8'h05);
        @(posedge clk); #1;
        sw  = {2'b00, C_ADD};
        btn = 3'b100;
        repeat (D + 2) @(posedge clk);
        #1;
        exp_v = ev(8'h00, 0, 0, 0, 2'd2);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lat_exec: got=%h want=%h", obs, exp_v); end
        @(posedge clk); #1;
        exp_v = ev(8'h45, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL lat_valid: got=%h want=%h", obs, exp_v); end
        btn = '0;
        repeat (SETTLE) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_exec();
        press(3'b001, 8'h40);
        press(3'b010, 8'h05);
        @(posedge clk); #1;
        sw  = {2'b00, C_ADD};
        btn = 3'b100;
        repeat (D + 2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        btn   = 3'b001;
        sw    = 8'h31;
        #1;
        exp_v = ev(8'h00, 0, 0, 0, 2'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL async_reset: got=%h want=%h", obs, exp_v); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (HOLD + 2) @(posedge clk);
        #1 sw = 8'h0E;
        repeat (10) @(posedge clk);
        #1 btn = '0;
        repeat (SETTLE) @(posedge clk);
        #1;
        exp_v = ev(8'h00, 0, 0, 0, 2'd1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL held_release_state: got=%h want=%h", obs, exp_v); end
        press(3'b010, 8'h01);
        press(3'b100, {2'b00, C_ADD});
        exp_v = ev(8'h32, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL held_release_once: got=%h want=%h", obs, exp_v); end
    endtask

`ifdef TOP_ALU_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        sw = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            btn[0] = ~btn[0];
            repeat (3) @(posedge clk);
            #1;
        end
        btn = '0;
        repeat (SETTLE) @(posedge clk);
        #1;
        total++;
        if (st !== 2'd0) begin bad++; $display("FAIL deb_bounce: got=%0d want=0", st); end
        @(posedge clk); #1;
        sw  = 8'h21;
        btn = 3'b001;
        repeat (20) @(posedge clk);
        #1 btn = '0;
        sw = 8'h99;
        repeat (SETTLE) @(posedge clk);
        #1;
        total++;
        if (st !== 2'd1) begin bad++; $display("FAIL deb_hold_state: got=%0d want=1", st); end
        press(3'b010, 8'h01);
        press(3'b100, {2'b00, C_ADD});
        exp_v = ev(8'h22, 1, 0, 0, 2'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL deb_hold_value: got=%h want=%h", obs, exp_v); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ignored();
        test_shift();
        test_random();
        test_latency();
        test_reset_exec();
`ifdef TOP_ALU_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
